fifo_wr_arbiter: RTL

Write-side arbiter that shares one FIFO write port among NREQ requesters. Each requester presents a word with a valid/ready-style req/gnt pair. The block picks requesters round-robin, lets each winner write a bounded burst, and never writes while fifo_full is high. It sits directly in front of the FIFO, driving fifo_write and fifo_data_in.

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/fifo_wr_arbiter_if.sv | 22 ++
 rtl/rr_pick.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE = 1'b0, ARB_BURST = 1'b1} arb_state_t;

    localparam int STALL_CNT_W   = 16;
    localparam int DEF_NREQ      = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BURST = 4;

    function automatic int next_idx(input int idx, input int nreq);
        return (idx + 1 >= nreq) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side write handshake bundle for fifo_wr_arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  fifo_full;
    logic                  fifo_write;
    logic [WIDTH-1:0]      fifo_data_in;

    modport master (
        output req, req_data, fifo_full,
        input  gnt, fifo_write, fifo_data_in
    );

    modport slave (
        input  req, req_data, fifo_full,
        output gnt, fifo_write, fifo_data_in
    );
endinterface

// File: rtl/rr_pick.sv
// Cyclic priority picker: first set bit of req at or after rr_ptr, wrapping.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);
    int            c;
    logic [IW-1:0] ci;

    // Scan from the farthest offset down so the nearest match wins.
    always_comb begin
        valid = |req;
        idx   = '0;
        c     = 0;
        ci    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            c  = (int'(rr_ptr) + k) % NREQ;
            ci = IW'(c);
            if (req[ci]) idx = ci;
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ requesters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ      = DEF_NREQ,
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int MAX_BURST = DEF_MAX_BURST,
    localparam int IW        = $clog2(NREQ),
    localparam int BW        = $clog2(MAX_BURST + 1)
) (
    input  logic                   clk,
    input  logic                   rst_,
    fifo_wr_arbiter_if.slave       bus,
    output logic [IW-1:0]          owner,
    output logic                   busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    arb_state_t      state, state_nxt;
    logic [IW-1:0]   rr_ptr, rr_nxt, owner_nxt;
    logic [BW-1:0]   burst_cnt, burst_nxt;
    logic [NREQ-1:0] gnt_vec;
    logic [WIDTH-1:0] data_mux;
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .valid  (pick_vld),
        .idx    (pick_idx)
    );

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        owner_nxt = owner;
        burst_nxt = burst_cnt;
        gnt_vec   = '0;
        if (rst_) begin
            case (state)
                ARB_IDLE: begin
                    if (pick_vld && !bus.fifo_full) begin
                        gnt_vec[pick_idx] = 1'b1;
                        owner_nxt         = pick_idx;
                        burst_nxt         = BW'(1);
                        if (MAX_BURST == 1) rr_nxt = IW'(next_idx(int'(pick_idx), NREQ));
                        else                state_nxt = ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    if (!bus.req[owner]) begin
                        // Owner went away: one bubble, then rearbitrate past it.
                        state_nxt = ARB_IDLE;
                        rr_nxt    = IW'(next_idx(int'(owner), NREQ));
                    end else if (!bus.fifo_full) begin
                        gnt_vec[owner] = 1'b1;
                        burst_nxt      = BW'(int'(burst_cnt) + 1);
                        if (int'(burst_cnt) + 1 == MAX_BURST) begin
                            state_nxt = ARB_IDLE;
                            rr_nxt    = IW'(next_idx(int'(owner), NREQ));
                        end
                    end
                end
                default: state_nxt = ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        data_mux = '0;
        for (int i = 0; i < NREQ; i++)
            data_mux |= {WIDTH{gnt_vec[i]}} & bus.req_data[i*WIDTH +: WIDTH];
    end

    assign bus.gnt          = gnt_vec;
    assign bus.fifo_write   = |gnt_vec;
    assign bus.fifo_data_in = data_mux;
    assign busy             = (state == ARB_BURST);

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_nxt;
            if (|bus.req && bus.fifo_full && stall_cnt != '1)
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end
endmodule
